// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: per-cycle advance/hold/bubble decisions for
// PC, IF/ID, ID/EX and EX/MEM covering load-use, branch flush, MDU and memory waits.
module hazard_stall_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_reg_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MDU  = 2'd1,
    ST_MEMW = 2'd2
  } state_t;

  localparam logic [4:0] MDU_LOAD = 5'(MDU_LATENCY - 1);

  state_t           state_q, state_d;
  logic [4:0]       mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  logic             run_rules;

  assign load_use = id_ex_memread && (id_ex_reg_rt != 5'd0) &&
                    ((id_ex_reg_rt == if_id_rs) || (id_ex_reg_rt == if_id_rt));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_done      = 1'b0;
    state_d       = state_q;
    mdu_cnt_d     = mdu_cnt_q;
    run_rules     = 1'b0;

    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            state_d      = ST_MEMW;
          end else begin
            run_rules = 1'b1;
          end
        end
        ST_MEMW: begin
          // A completing access releases the freeze and lets ID/EX hazards act now.
          if (!mem_ready) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
          end else begin
            state_d   = ST_RUN;
            run_rules = 1'b1;
          end
        end
        ST_MDU: begin
          if (mdu_cnt_q == 5'd1) begin
            mdu_done  = 1'b1;
            mdu_cnt_d = 5'd0;
            state_d   = ST_RUN;
          end else begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            mdu_cnt_d     = mdu_cnt_q - 5'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase

      if (run_rules) begin
        if (mdu_start) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          mdu_cnt_d     = MDU_LOAD;
          state_d       = ST_MDU;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          // ID/EX keeps its write enable so the flush inserts the bubble.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mdu_cnt_q   <= 5'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = rst ? '0 : stall_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: cycle-level behavioural model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_hazard_stall_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_ex_memread;
  logic [4:0]    id_ex_reg_rt, if_id_rs, if_id_rt;
  logic          branch_taken, mdu_start, mem_req, mem_ready;
  logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic          if_id_flush, id_ex_flush, ex_mem_bubble, mdu_done;
  logic [CW-1:0] stall_count;
  logic [1:0]    dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_stall_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_ex_memread(id_ex_memread), .id_ex_reg_rt(id_ex_reg_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .branch_taken(branch_taken), .mdu_start(mdu_start),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble), .mdu_done(mdu_done),
    .stall_count(stall_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // model: cycles of EX occupancy left for an MDU op, memory-wait flag, stall count
  int   m_left  = 0;
  bit   m_memw  = 1'b0;
  int   m_count = 0;
  int   nx_left;
  bit   nx_memw;
  bit   nx_pc;

  // {pc, if_id, id_ex, ex_mem writes, if_id_flush, id_ex_flush, bubble, done}
  always @(negedge clk) begin
    logic [7:0] e;
    bit lu, frozen;
    e = 8'b1111_0000;
    nx_left = m_left;
    nx_memw = m_memw;
    if (!rst) begin
      lu = id_ex_memread && id_ex_reg_rt != 0 &&
           (id_ex_reg_rt == if_id_rs || id_ex_reg_rt == if_id_rt);
      frozen = m_memw ? !mem_ready : (mem_req && !mem_ready);
      if (m_left == 1) begin
        e[0] = 1'b1;
        nx_left = 0;
      end else if (m_left > 1) begin
        e[7:5] = 3'b000;
        e[1] = 1'b1;
        nx_left = m_left - 1;
      end else if (frozen) begin
        e[7:4] = 4'b0000;
        nx_memw = 1'b1;
      end else begin
        nx_memw = 1'b0;
        if (mdu_start) begin
          e[7:5] = 3'b000;
          e[1] = 1'b1;
          nx_left = LAT - 1;
        end else if (branch_taken) begin
          e[3:2] = 2'b11;
        end else if (lu) begin
          e[7:6] = 2'b00;
          e[2] = 1'b1;
        end
      end
    end
    nx_pc = e[7];
    check("outputs", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write,
                          if_id_flush, id_ex_flush, ex_mem_bubble, mdu_done}), 32'(e));
    check("stall_count", 32'(stall_count), rst ? 32'd0 : 32'(m_count));
  end

  always @(posedge clk) begin
    if (rst) begin
      m_left  <= 0;
      m_memw  <= 1'b0;
      m_count <= 0;
    end else begin
      m_left <= nx_left;
      m_memw <= nx_memw;
      if (!nx_pc && m_count < CMAX) m_count <= m_count + 1;
    end
  end

  // driver tasks: new inputs 1 time unit after the edge, sampled at negedge+1
  task automatic apply(input logic r, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic br,
                       input logic ms, input logic mq, input logic my);
    @(posedge clk); #1;
    rst = r; id_ex_memread = mr; id_ex_reg_rt = ert; if_id_rs = rs; if_id_rt = rt;
    branch_taken = br; mdu_start = ms; mem_req = mq; mem_ready = my;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; id_ex_memread = 0; id_ex_reg_rt = 0; if_id_rs = 0; if_id_rt = 0;
    branch_taken = 0; mdu_start = 0; mem_req = 0; mem_ready = 0;

    // T1 reset held two cycles
    @(negedge clk); #1;
    check("rst1_pc", 32'(pc_write), 1);
    check("rst1_cnt", 32'(stall_count), 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst2_flush", 32'({if_id_flush, id_ex_flush}), 0);
    check("rst2_cnt", 32'(stall_count), 0);
    idle();
    check("idle_pc", 32'(pc_write), 1);

    // T2 load-use on rs, then rt=0, then match on rt
    apply(0, 1, 5, 5, 0, 0, 0, 0, 0);
    check("lu_pc", 32'(pc_write), 0);
    check("lu_bubble", 32'({if_id_write, id_ex_write, id_ex_flush}), 32'b011);
    idle();
    check("lu_once", 32'(pc_write), 1);
    check("lu_cnt", 32'(stall_count), 1);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("lu_r0", 32'({pc_write, id_ex_flush}), 32'b10);
    apply(0, 1, 7, 3, 7, 0, 0, 0, 0);
    check("lu_rt", 32'(pc_write), 0);

    // T3 branch beats load-use
    apply(0, 1, 7, 7, 7, 1, 0, 0, 0);
    check("br_flush", 32'({pc_write, if_id_flush, id_ex_flush}), 32'b111);
    check("br_cnt", 32'(stall_count), 2);
    idle();
    check("br_cnt2", 32'(stall_count), 2);

    // T4 MDU op; events during MDU are ignored
    apply(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("mdu1", 32'({pc_write, ex_mem_bubble, mdu_done}), 32'b010);
    apply(0, 1, 4, 4, 0, 1, 0, 1, 0);
    check("mdu2", 32'({pc_write, ex_mem_write, if_id_flush, ex_mem_bubble}), 32'b0101);
    idle();
    check("mdu3", 32'(pc_write), 0);
    idle();
    check("mdu4_done", 32'({pc_write, ex_mem_bubble, mdu_done}), 32'b101);
    idle();
    check("mdu_cnt", 32'(stall_count), 5);
    check("mdu_pulse", 32'(mdu_done), 0);

    // T5 memory wait (freeze beats mdu_start), ready with load-use
    apply(0, 0, 0, 0, 0, 0, 1, 1, 0);
    check("mw1", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write, ex_mem_bubble}), 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("mw3", 32'({pc_write, ex_mem_write}), 0);
    apply(0, 1, 9, 9, 0, 0, 0, 1, 1);
    check("mw_lu", 32'({pc_write, if_id_write, id_ex_flush, ex_mem_write}), 32'b0011);
    idle();
    check("mw_cnt", 32'(stall_count), 9);
    // MEMW exit straight into an MDU op
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 1, 1);
    check("mw_mdu", 32'({pc_write, ex_mem_bubble}), 32'b01);
    idle(); idle(); idle();
    check("mw_mdu_done", 32'(mdu_done), 1);
    idle();
    check("mw_mdu_cnt", 32'(stall_count), 13);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("mem_hit", 32'({pc_write, ex_mem_write}), 32'b11);

    // T6 reset in the second MDU cycle
    apply(0, 0, 0, 0, 0, 0, 1, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mdu", 32'({pc_write, mdu_done}), 32'b10);
    idle();
    check("rst_mdu_run", 32'({pc_write, mdu_done}), 32'b10);
    check("rst_mdu_cnt", 32'(stall_count), 0);
    idle(); idle();
    check("rst_no_done", 32'(mdu_done), 0);

    // counter saturation
    for (int i = 0; i < 35; i++) apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    check("cnt_sat", 32'(stall_count), CMAX);

    // random mixture, model-checked every cycle
    for (int i = 0; i < 300; i++) begin
      apply($urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    idle();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
